// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo_if
//  Purpose  : Bus-side signal bundle of the UART transmitter peripheral.
//             The bus decode (master) issues one-cycle byte writes. The
//             peripheral (slave) reports FIFO status and drives the line.
//  Signals  : wr_en     write strobe, one cycle per byte
//             wr_data   byte to enqueue
//             full      FIFO holds DEPTH entries
//             empty     FIFO holds no entries
//             count     FIFO occupancy, 0..DEPTH
//             busy      serialiser is not idle
//             overflow  sticky: a write was dropped while full
//             txd       serial output, idles high
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int AW = 3
);
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          busy;
    logic          overflow;
    logic          txd;

    modport master (
        output wr_en, wr_data,
        input  full, empty, count, busy, overflow, txd
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, count, busy, overflow, txd
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Memory-mapped UART transmitter. Bytes written by the bus are
//             buffered in a DEPTH-entry circular FIFO and serialised as 8N1
//             frames (start 0, d0..d7 LSB first, stop 1). Each bit lasts
//             CLK_DIV clock cycles.
//  Ports    : clk     system clock, rising edge
//             rst     synchronous reset, active-high
//             bus_if  slave side of uart_tx_fifo_if (write strobe/data in;
//                     full, empty, count, busy, overflow, txd out)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_DIV = 104,
    parameter int DEPTH   = 8,
    parameter int AW      = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    uart_tx_fifo_if.slave     bus_if
);

    localparam int              BW          = $clog2(CLK_DIV);
    localparam logic [BW-1:0]   BAUD_RELOAD = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0]   BAUD_ONE    = BW'(1);
    localparam logic [AW:0]     CNT_ONE     = (AW+1)'(1);
    localparam logic [AW:0]     CNT_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE     = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     sh_q, sh_d;
    logic           txd_q, txd_d;
    logic           busy_q;
    logic [AW:0]    count_q, count_d;
    logic           full_q, empty_q, overflow_q;
    logic [AW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [7:0]     mem_q [DEPTH];

    logic           pop;
    logic           wr_accept;
    logic           tick;
    logic [7:0]     head;

    // Full is the registered pre-edge value, so a pop on the same edge
    // does not make room for a write.
    assign wr_accept = bus_if.wr_en && !full_q;
    assign tick      = (baud_q == '0);
    assign head      = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Serialiser next-state and pop decision
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        pop     = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = tick ? BAUD_RELOAD : (baud_q - BAUD_ONE);
        end

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!empty_q) begin
                    pop     = 1'b1;
                    sh_d    = head;
                    txd_d   = 1'b0;
                    baud_d  = BAUD_RELOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    txd_d   = sh_q[0];
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (idx_q != 3'd7) begin
                        // sh_q[0] is on the line; the next bit is sh_q[1].
                        sh_d  = sh_q >> 1;
                        txd_d = sh_q[1];
                        idx_d = idx_q + 3'd1;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (!empty_q) begin
                        // Chain straight into the next start bit.
                        pop     = 1'b1;
                        sh_d    = head;
                        txd_d   = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Occupancy update
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage array carries no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= bus_if.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            idx_q      <= '0;
            sh_q       <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            sh_q     <= sh_d;
            txd_q    <= txd_d;
            busy_q   <= (state_d != S_IDLE);
            count_q  <= count_d;
            full_q   <= (count_d == CNT_FULL);
            empty_q  <= (count_d == '0);
            if (bus_if.wr_en && full_q) begin
                overflow_q <= 1'b1;
            end
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    assign bus_if.txd      = txd_q;
    assign bus_if.busy     = busy_q;
    assign bus_if.count    = count_q;
    assign bus_if.full     = full_q;
    assign bus_if.empty    = empty_q;
    assign bus_if.overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Self-checking bench for uart_tx_fifo. A frame-level model
//             (byte queue plus position within the current frame) predicts
//             every output each cycle; a table of hand-computed literal
//             expectations pins the model at chosen cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CD    = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int FRAME = 10 * CD;
    localparam int NOMARK = 32'h3fff_ffff;

    logic clk;
    logic rst;

    uart_tx_fifo_if #(.AW(AW)) bus ();

    uart_tx_fifo #(
        .CLK_DIV (CD),
        .DEPTH   (DEPTH),
        .AW      (AW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] m_q [$];
    logic [7:0] m_cur;
    bit         m_active;
    int         m_pos;
    bit         m_ovf;
    bit         m_valid;
    int         cyc;

    function automatic logic exp_txd();
        int b;
        if (!m_active) return 1'b1;
        b = m_pos / CD;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    initial begin
        m_active = 0; m_pos = 0; m_ovf = 0; m_valid = 0; cyc = 0; m_cur = 8'h00;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (rst) begin
                m_q.delete();
                m_active = 0;
                m_pos    = 0;
                m_ovf    = 0;
                m_valid  = 1;
            end else begin
                int sz;
                sz = m_q.size();
                if (m_active) begin
                    if (m_pos == FRAME - 1) begin
                        if (sz > 0) begin
                            m_cur = m_q.pop_front();
                            m_pos = 0;
                        end else begin
                            m_active = 0;
                        end
                    end else begin
                        m_pos = m_pos + 1;
                    end
                end else if (sz > 0) begin
                    m_cur    = m_q.pop_front();
                    m_active = 1;
                    m_pos    = 0;
                end
                if (bus.wr_en) begin
                    if (sz == DEPTH) m_ovf = 1;
                    else             m_q.push_back(bus.wr_data);
                end
            end
        end
    end

    // ---------------- literal expectations ----------------
    // signal codes: 0 txd, 1 busy, 2 count, 3 empty, 4 full, 5 overflow
    localparam int NL = 41;
    localparam int LM [NL] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,
                               5,5,5,5,5,5,5,5,
                               1,1,1,1,1,
                               2,2,2,
                               3,
                               4,4,4,4,4,
                               6,6,6,6,6,6};
    localparam int LO [NL] = '{0,0,1,1,1,4,5,9,36,37,40,41,41,
                               5,9,40,41,41,45,49,53,
                               0,0,0,8,8,
                               0,0,0,
                               0,
                               0,0,0,0,0,
                               0,0,0,0,0,0};
    localparam int LS [NL] = '{2,3,0,1,2,0,0,0,0,0,1,1,0,
                               0,0,0,0,1,0,0,0,
                               2,4,5,5,2,
                               2,5,4,
                               2,
                               0,1,2,3,5,
                               0,1,2,3,4,5};
    localparam int LV [NL] = '{1,0,0,1,0,0,1,0,0,1,1,0,1,
                               1,0,1,0,1,0,0,1,
                               8,1,1,1,8,
                               7,1,0,
                               3,
                               1,0,0,1,0,
                               1,0,0,1,0,0};
    int marks [7];

    // ---------------- compare process ----------------
    int  errors;
    int  checks;
    bit  done;
    bit  tmo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_sig(input int s);
        case (s)
            0: return {31'd0, bus.txd};
            1: return {31'd0, bus.busy};
            2: return {28'd0, bus.count};
            3: return {31'd0, bus.empty};
            4: return {31'd0, bus.full};
            default: return {31'd0, bus.overflow};
        endcase
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("txd",      {31'd0, bus.txd},      {31'd0, exp_txd()});
                chk("busy",     {31'd0, bus.busy},     {31'd0, m_active});
                chk("count",    {28'd0, bus.count},    m_q.size());
                chk("full",     {31'd0, bus.full},     {31'd0, m_q.size() == DEPTH});
                chk("empty",    {31'd0, bus.empty},    {31'd0, m_q.size() == 0});
                chk("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
                for (int i = 0; i < NL; i++) begin
                    if (marks[LM[i]] != NOMARK && cyc == marks[LM[i]] + LO[i])
                        chk($sformatf("lit%0d", i), dut_sig(LS[i]), LV[i]);
                end
            end
            if (done) begin
                chk("stim_timeout", {31'd0, tmo}, 32'd0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 2000 && (m_active || m_q.size() != 0); k++) @(negedge clk);
        if (m_active || m_q.size() != 0) tmo = 1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        done = 0; tmo = 0;
        for (int i = 0; i < 7; i++) marks[i] = NOMARK;
        marks[6]    = 2;
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // single byte
        marks[0] = cyc + 1;
        wr(8'h55);
        wait_idle();

        // back-to-back frames
        marks[5] = cyc + 1;
        wr(8'hA5);
        wr(8'h3C);
        wait_idle();

        // fill and overflow while a frame is on the line
        wr(8'h11);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            if (i == 8) marks[1] = cyc + 1;
            wr(8'h80 + 8'(i));
        end

        // write at full coinciding with a stop-tick pop
        for (int k = 0; k < 200 && !(m_active && m_pos == FRAME-1 && m_q.size() == DEPTH); k++)
            @(negedge clk);
        if (!(m_active && m_pos == FRAME-1 && m_q.size() == DEPTH)) tmo = 1;
        marks[2] = cyc + 1;
        wr(8'hEE);

        // accepted write coinciding with a pop at count 3
        for (int k = 0; k < 1000 && !(m_active && m_pos == FRAME-1 && m_q.size() == 3); k++)
            @(negedge clk);
        if (!(m_active && m_pos == FRAME-1 && m_q.size() == 3)) tmo = 1;
        marks[3] = cyc + 1;
        wr(8'hC3);
        wait_idle();

        // reset during data bit 3 of 0xFF with two bytes queued
        wr(8'hFF);
        wr(8'h01);
        wr(8'h02);
        for (int k = 0; k < 200 && !(m_active && m_cur == 8'hFF && m_pos == 4*CD + 1); k++)
            @(negedge clk);
        if (!(m_active && m_cur == 8'hFF && m_pos == 4*CD + 1)) tmo = 1;
        marks[4] = cyc + 1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        done = 1;
    end

endmodule
`default_nettype wire
